// File: rtl/port_desc_reader_pkg.sv
// rtl/port_desc_reader_pkg.sv - shared defaults, FSM state type and port helpers for port_desc_reader
// Contents:
//   DEF_*            default geometry shared with the ingress pre-arbiter
//   rd_state_t       reader FSM states
//   onehot_to_port   one-hot FIFO grant -> output port number (1..3)
package port_desc_reader_pkg;

  localparam int DEF_PORT_NUM   = 4;
  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_DEPTH_RAM  = 256;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FREE  = 2'd3
  } rd_state_t;

  // Output ports are numbered from 1; port 0 is the ingress side.
  function automatic logic [1:0] onehot_to_port(input logic [2:0] onehot);
    logic [1:0] port;
    port = 2'd0;
    if (onehot[0])      port = 2'd1;
    else if (onehot[1]) port = 2'd2;
    else if (onehot[2]) port = 2'd3;
    return port;
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// rtl/rr_arbiter_3.sv - combinational 3-request round-robin pick
// Ports:
//   req_i   [2:0]  request per output port (bit k-1 = port k)
//   last_i  [1:0]  port number (1..3) served last; search starts after it
//   gnt_o   [2:0]  one-hot grant, zero when nothing requests
//   valid_o        at least one request present
module rr_arbiter_3 (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  always_comb begin
    gnt_o = 3'b000;
    case (last_i)
      2'd1: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd2: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      // 3 (and the unused code 0) start the search at port 1
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/port_desc_reader.sv
// rtl/port_desc_reader.sv - drains per-port descriptor FIFOs round-robin and streams packets from packet RAM
// Ports:
//   iclk, irst_n                 clock, asynchronous active-low reset
//   i_desc_valid [2:0]           per-port descriptor FIFO not empty
//   i_desc_1..3                  show-ahead FIFO heads, {length, ptr}
//   o_desc_pop [2:0]             one-cycle pop strobe per FIFO
//   i_port_ready [2:0]           per-port downstream ready
//   o_ram_rd_en, o_ram_rd_addr   packet RAM read request
//   i_ram_rd_data                RAM data, one cycle after the request
//   o_port_num                   output port being served
//   o_data, o_data_valid         packet word stream
//   o_sop, o_eop                 first / last word markers
//   o_free_valid, o_free_ptr     start pointer returned to the free list
module port_desc_reader
  import port_desc_reader_pkg::*;
#(
  parameter int pPORT_NUM   = DEF_PORT_NUM,
  parameter int pFIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int pDEPTH_RAM  = DEF_DEPTH_RAM,
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                        iclk,
  input  logic                                        irst_n,
  input  logic [2:0]                                  i_desc_valid,
  input  logic [pFIFO_WIDTH+$clog2(pDEPTH_RAM)-1:0]   i_desc_1,
  input  logic [pFIFO_WIDTH+$clog2(pDEPTH_RAM)-1:0]   i_desc_2,
  input  logic [pFIFO_WIDTH+$clog2(pDEPTH_RAM)-1:0]   i_desc_3,
  output logic [2:0]                                  o_desc_pop,
  input  logic [2:0]                                  i_port_ready,
  output logic                                        o_ram_rd_en,
  output logic [$clog2(pDEPTH_RAM)-1:0]               o_ram_rd_addr,
  input  logic [pDATA_WIDTH-1:0]                      i_ram_rd_data,
  output logic [$clog2(pPORT_NUM)-1:0]                o_port_num,
  output logic [pDATA_WIDTH-1:0]                      o_data,
  output logic                                        o_data_valid,
  output logic                                        o_sop,
  output logic                                        o_eop,
  output logic                                        o_free_valid,
  output logic [$clog2(pDEPTH_RAM)-1:0]               o_free_ptr
);

  localparam int PTR_W  = $clog2(pDEPTH_RAM);
  localparam int DESC_W = pFIFO_WIDTH + PTR_W;
  localparam int PN_W   = $clog2(pPORT_NUM);

  rd_state_t               state_q;
  logic [1:0]              last_q;
  logic [2:0]              sel_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [pFIFO_WIDTH-1:0]  len_q;
  logic [pFIFO_WIDTH-1:0]  cnt_q;
  logic [PN_W-1:0]         port_num_q;
  logic                    data_valid_q;
  logic                    sop_q;
  logic                    eop_q;
  logic                    free_valid_q;

  logic [2:0]              gnt;
  logic                    gnt_valid;
  logic                    take;
  logic [DESC_W-1:0]       desc_sel;
  logic [PTR_W-1:0]        desc_ptr;
  logic [pFIFO_WIDTH-1:0]  desc_len;
  logic                    rd_en;
  logic                    last_rd;

  rr_arbiter_3 u_arb (
    .req_i   (i_desc_valid & i_port_ready),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  assign take = (state_q == ST_IDLE) && gnt_valid;

  always_comb begin
    desc_sel = i_desc_3;
    if (gnt[0])      desc_sel = i_desc_1;
    else if (gnt[1]) desc_sel = i_desc_2;
  end

  assign desc_ptr = desc_sel[PTR_W-1:0];
  assign desc_len = desc_sel[DESC_W-1:PTR_W];

  // Reads follow the served port's ready with no extra register, so exactly
  // one word (the read already in flight) arrives after ready drops.
  assign rd_en   = (state_q == ST_READ) && |(i_port_ready & sel_q);
  assign last_rd = rd_en && (cnt_q == len_q - pFIFO_WIDTH'(1));

  // The pop is issued in the same cycle as the IDLE decision so the descriptor
  // is captured on that edge; holding reset forces it low regardless of inputs.
  assign o_desc_pop    = (take && irst_n) ? gnt : 3'b000;
  assign o_ram_rd_en   = rd_en;
  assign o_ram_rd_addr = rd_en ? ptr_q + PTR_W'(cnt_q) : '0;
  assign o_port_num    = port_num_q;
  assign o_data        = data_valid_q ? i_ram_rd_data : '0;
  assign o_data_valid  = data_valid_q;
  assign o_sop         = sop_q;
  assign o_eop         = eop_q;
  assign o_free_valid  = free_valid_q;
  assign o_free_ptr    = free_valid_q ? ptr_q : '0;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= 2'd3;
      sel_q        <= 3'b000;
      ptr_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      port_num_q   <= '0;
      data_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      free_valid_q <= 1'b0;
    end else begin
      // Word markers travel with the RAM's one-cycle read latency.
      data_valid_q <= rd_en;
      sop_q        <= rd_en && (cnt_q == '0);
      eop_q        <= last_rd;
      free_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            sel_q      <= gnt;
            port_num_q <= PN_W'(onehot_to_port(gnt));
            ptr_q      <= desc_ptr;
            len_q      <= desc_len;
            cnt_q      <= '0;
            if (desc_len == '0) begin
              state_q      <= ST_FREE;
              free_valid_q <= 1'b1;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_en) begin
            cnt_q <= cnt_q + pFIFO_WIDTH'(1);
            if (last_rd) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_FREE;
          free_valid_q <= 1'b1;
        end
        ST_FREE: begin
          last_q  <= onehot_to_port(sel_q);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_desc_reader.sv
// tb/tb_port_desc_reader.sv - self-checking bench for port_desc_reader
module tb_port_desc_reader;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [2:0]  i_desc_valid;
  logic [15:0] i_desc_1, i_desc_2, i_desc_3;
  logic [2:0]  o_desc_pop;
  logic [2:0]  i_port_ready;
  logic        o_ram_rd_en;
  logic [7:0]  o_ram_rd_addr;
  logic [7:0]  i_ram_rd_data;
  logic [1:0]  o_port_num;
  logic [7:0]  o_data;
  logic        o_data_valid, o_sop, o_eop, o_free_valid;
  logic [7:0]  o_free_ptr;

  logic [7:0]  mem [256];
  logic [7:0]  rd_data_q = 8'h00;

  typedef struct {
    int cyc;
    int a;
    int b;
    bit s;
    bit e;
    int p;
  } ev_t;

  ev_t pops[$], rds[$], words[$], frees[$];
  logic [15:0] dq1[$], dq2[$], dq3[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  logic [2:0] drop_mask = 3'b000;
  int   drop_lo = 0;
  int   drop_hi = 0;

  port_desc_reader #(
    .pPORT_NUM(4), .pFIFO_WIDTH(8), .pDEPTH_RAM(256), .pDATA_WIDTH(8)
  ) dut (
    .iclk(iclk), .irst_n(irst_n),
    .i_desc_valid(i_desc_valid),
    .i_desc_1(i_desc_1), .i_desc_2(i_desc_2), .i_desc_3(i_desc_3),
    .o_desc_pop(o_desc_pop), .i_port_ready(i_port_ready),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr),
    .i_ram_rd_data(i_ram_rd_data), .o_port_num(o_port_num),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .o_sop(o_sop), .o_eop(o_eop),
    .o_free_valid(o_free_valid), .o_free_ptr(o_free_ptr)
  );

  always #5 iclk = ~iclk;

  // Packet RAM: registered read, one cycle latency.
  always @(posedge iclk) if (o_ram_rd_en) rd_data_q <= mem[o_ram_rd_addr];
  assign i_ram_rd_data = rd_data_q;

  function automatic int rr_pick(input logic [2:0] elig, input int last);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = ((last - 1 + k) % 3) + 1;
      if (elig[p-1]) return p;
    end
    return 0;
  endfunction

  function automatic int qsize(input int p);
    if (p == 1) return dq1.size();
    if (p == 2) return dq2.size();
    return dq3.size();
  endfunction

  function automatic logic [15:0] qhead(input int p);
    if (p == 1) return (dq1.size() != 0) ? dq1[0] : 16'h0;
    if (p == 2) return (dq2.size() != 0) ? dq2[0] : 16'h0;
    return (dq3.size() != 0) ? dq3[0] : 16'h0;
  endfunction

  task automatic refresh_heads();
    i_desc_valid = {dq3.size() != 0, dq2.size() != 0, dq1.size() != 0};
    i_desc_1 = qhead(1);
    i_desc_2 = qhead(2);
    i_desc_3 = qhead(3);
  endtask

  task automatic push(input int p, input logic [7:0] len, input logic [7:0] ptr);
    if (p == 1)      dq1.push_back({len, ptr});
    else if (p == 2) dq2.push_back({len, ptr});
    else             dq3.push_back({len, ptr});
    refresh_heads();
    #1;
  endtask

  task automatic log_cycle();
    if (o_desc_pop != 3'b000) pops.push_back('{cyc, int'(o_desc_pop), 0, 1'b0, 1'b0, 0});
    if (o_ram_rd_en) rds.push_back('{cyc, int'(o_ram_rd_addr), int'(i_port_ready), 1'b0, 1'b0, int'(o_port_num)});
    if (o_data_valid) words.push_back('{cyc, 0, int'(o_data), o_sop, o_eop, int'(o_port_num)});
    if (o_free_valid) frees.push_back('{cyc, int'(o_free_ptr), 0, 1'b0, 1'b0, 0});
  endtask

  task automatic clear_logs();
    pops.delete(); rds.delete(); words.delete(); frees.delete();
  endtask

  // Advance one clock: retire popped FIFO heads, apply next ready, settle, log.
  task automatic tick();
    logic [2:0] pop_s;
    pop_s = o_desc_pop;
    @(posedge iclk);
    #1;
    if (pop_s[0] && dq1.size() != 0) void'(dq1.pop_front());
    if (pop_s[1] && dq2.size() != 0) void'(dq2.pop_front());
    if (pop_s[2] && dq3.size() != 0) void'(dq3.pop_front());
    cyc++;
    if (rand_ready) begin
      for (int k = 0; k < 3; k++) i_port_ready[k] = ($urandom_range(0, 3) != 0);
    end else begin
      i_port_ready = 3'b111 & ~((cyc >= drop_lo && cyc < drop_hi) ? drop_mask : 3'b000);
    end
    refresh_heads();
    #1;
    log_cycle();
  endtask

  task automatic run(input int n);
    log_cycle();
    repeat (n) tick();
  endtask

  task automatic reset_dut();
    irst_n = 1'b0;
    dq1.delete(); dq2.delete(); dq3.delete();
    rand_ready = 1'b0;
    drop_mask = 3'b000;
    i_port_ready = 3'b111;
    refresh_heads();
    tick();
    tick();
    irst_n = 1'b1;
    #1;
    clear_logs();
  endtask

  task automatic test_reset();
    irst_n = 1'b0;
    i_port_ready = 3'b111;
    refresh_heads();
    tick();
    push(1, 8'd3, 8'h10);
    checks++;
    if (o_desc_pop !== 3'b000 || o_ram_rd_en !== 1'b0 || o_ram_rd_addr !== 8'h00 || o_data_valid !== 1'b0)
      begin errors++; $display("FAIL reset_req pop=%b rd_en=%b addr=%h dv=%b required 000/0/00/0", o_desc_pop, o_ram_rd_en, o_ram_rd_addr, o_data_valid); end
    checks++;
    if (o_sop !== 1'b0 || o_eop !== 1'b0 || o_free_valid !== 1'b0 || o_free_ptr !== 8'h00 || o_port_num !== 2'd0 || o_data !== 8'h00)
      begin errors++; $display("FAIL reset_out sop=%b eop=%b fv=%b fp=%h pn=%0d d=%h required all 0", o_sop, o_eop, o_free_valid, o_free_ptr, o_port_num, o_data); end
    irst_n = 1'b1;
    #1;
    checks++;
    if (o_desc_pop !== 3'b001) begin errors++; $display("FAIL reset_first_port got=%b required=001", o_desc_pop); end
  endtask

  task automatic test_single();
    int t;
    reset_dut();
    push(2, 8'd3, 8'h10);
    t = cyc;
    run(12);
    checks++;
    if (pops.size() != 1 || pops[0].a != 2 || pops[0].cyc != t)
      begin errors++; $display("FAIL single_pop n=%0d mask=%0d cyc=%0d required 1/2/%0d", pops.size(), pops[0].a, pops[0].cyc, t); end
    checks++;
    if (rds.size() != 3) begin errors++; $display("FAIL single_reads got=%0d required=3", rds.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (rds[i].cyc != t + 1 + i || rds[i].a != 8'h10 + i)
        begin errors++; $display("FAIL single_read%0d cyc=%0d addr=%h required %0d/%h", i, rds[i].cyc, rds[i].a, t + 1 + i, 8'h10 + i); end
    end
    checks++;
    if (words.size() != 3) begin errors++; $display("FAIL single_words got=%0d required=3", words.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (words[i].cyc != t + 2 + i || words[i].b != int'(mem[8'h10 + i]) || words[i].s != (i == 0) || words[i].e != (i == 2) || words[i].p != 2)
        begin errors++; $display("FAIL single_word%0d cyc=%0d d=%h s=%0d e=%0d pn=%0d required %0d/%h/%0d/%0d/2", i, words[i].cyc, words[i].b, words[i].s, words[i].e, words[i].p, t + 2 + i, mem[8'h10 + i], i == 0, i == 2); end
    end
    checks++;
    if (frees.size() != 1 || frees[0].cyc != t + 5 || frees[0].a != 8'h10)
      begin errors++; $display("FAIL single_free n=%0d cyc=%0d ptr=%h required 1/%0d/10", frees.size(), frees[0].cyc, frees[0].a, t + 5); end
  endtask

  task automatic test_all_three();
    int t;
    reset_dut();
    push(1, 8'd1, 8'h50);
    push(2, 8'd1, 8'h60);
    push(3, 8'd1, 8'h70);
    t = cyc;
    run(20);
    checks++;
    if (pops.size() != 3 || words.size() != 3 || frees.size() != 3)
      begin errors++; $display("FAIL three_counts pops=%0d words=%0d frees=%0d required 3/3/3", pops.size(), words.size(), frees.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (pops[i].a != (1 << i) || pops[i].cyc != t + 4 * i)
        begin errors++; $display("FAIL three_pop%0d mask=%0d cyc=%0d required %0d/%0d", i, pops[i].a, pops[i].cyc, 1 << i, t + 4 * i); end
      checks++;
      if (!words[i].s || !words[i].e || words[i].p != i + 1 || words[i].b != int'(mem[8'h50 + 16 * i]))
        begin errors++; $display("FAIL three_word%0d s=%0d e=%0d pn=%0d d=%h required 1/1/%0d/%h", i, words[i].s, words[i].e, words[i].p, words[i].b, i + 1, mem[8'h50 + 16 * i]); end
      checks++;
      if (frees[i].a != 8'h50 + 16 * i)
        begin errors++; $display("FAIL three_free%0d ptr=%h required=%h", i, frees[i].a, 8'h50 + 16 * i); end
    end
  endtask

  task automatic test_ready_drop();
    int t, in_window;
    reset_dut();
    push(1, 8'd6, 8'h40);
    t = cyc;
    drop_mask = 3'b001;
    drop_lo = t + 3;
    drop_hi = t + 7;
    run(20);
    drop_mask = 3'b000;
    checks++;
    if (rds.size() != 6) begin errors++; $display("FAIL drop_reads got=%0d required=6", rds.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (rds[i].a != 8'h40 + i || rds[i].b[0] != 1'b1)
        begin errors++; $display("FAIL drop_read%0d addr=%h ready=%0d required %h/1", i, rds[i].a, rds[i].b[0], 8'h40 + i); end
    end
    in_window = 0;
    checks++;
    if (words.size() != 6) begin errors++; $display("FAIL drop_words got=%0d required=6", words.size()); end
    else for (int i = 0; i < 6; i++) begin
      if (words[i].cyc >= t + 3 && words[i].cyc < t + 7) in_window++;
      checks++;
      if (words[i].b != int'(mem[8'h40 + i]) || words[i].s != (i == 0) || words[i].e != (i == 5))
        begin errors++; $display("FAIL drop_word%0d d=%h s=%0d e=%0d required %h/%0d/%0d", i, words[i].b, words[i].s, words[i].e, mem[8'h40 + i], i == 0, i == 5); end
    end
    checks++;
    if (in_window != 1) begin errors++; $display("FAIL drop_extra_words got=%0d required=1", in_window); end
    checks++;
    if (frees.size() != 1 || frees[0].a != 8'h40)
      begin errors++; $display("FAIL drop_free n=%0d ptr=%h required 1/40", frees.size(), frees[0].a); end
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    reset_dut();
    push(1, 8'd4, 8'd254);
    run(12);
    checks++;
    if (rds.size() != 4 || words.size() != 4)
      begin errors++; $display("FAIL wrap_counts reads=%0d words=%0d required 4/4", rds.size(), words.size()); end
    else for (int i = 0; i < 4; i++) begin
      a = 8'((254 + i) % 256);
      checks++;
      if (rds[i].a != int'(a) || words[i].b != int'(mem[a]))
        begin errors++; $display("FAIL wrap_%0d addr=%0d d=%h required %0d/%h", i, rds[i].a, words[i].b, a, mem[a]); end
    end
  endtask

  task automatic test_len0();
    int t;
    reset_dut();
    push(3, 8'd0, 8'h77);
    t = cyc;
    run(6);
    checks++;
    if (pops.size() != 1 || pops[0].a != 4 || pops[0].cyc != t)
      begin errors++; $display("FAIL len0_pop n=%0d mask=%0d required 1/4", pops.size(), pops[0].a); end
    checks++;
    if (frees.size() != 1 || frees[0].cyc != t + 1 || frees[0].a != 8'h77)
      begin errors++; $display("FAIL len0_free n=%0d cyc=%0d ptr=%h required 1/%0d/77", frees.size(), frees[0].cyc, frees[0].a, t + 1); end
    checks++;
    if (words.size() != 0 || rds.size() != 0)
      begin errors++; $display("FAIL len0_data words=%0d reads=%0d required 0/0", words.size(), rds.size()); end
  endtask

  task automatic test_reset_midpacket();
    reset_dut();
    push(1, 8'd5, 8'h20);
    push(2, 8'd2, 8'h88);
    push(3, 8'd2, 8'h99);
    log_cycle();
    for (int i = 0; i < 20 && words.size() < 2; i++) tick();
    checks++;
    if (words.size() != 2) begin errors++; $display("FAIL midrst_wait words=%0d required=2", words.size()); end
    irst_n = 1'b0;
    #1;
    checks++;
    if (o_desc_pop !== 3'b000 || o_ram_rd_en !== 1'b0 || o_ram_rd_addr !== 8'h00 || o_data_valid !== 1'b0 || o_data !== 8'h00)
      begin errors++; $display("FAIL midrst_req pop=%b rd_en=%b addr=%h dv=%b d=%h required all 0", o_desc_pop, o_ram_rd_en, o_ram_rd_addr, o_data_valid, o_data); end
    checks++;
    if (o_sop !== 1'b0 || o_eop !== 1'b0 || o_free_valid !== 1'b0 || o_free_ptr !== 8'h00 || o_port_num !== 2'd0)
      begin errors++; $display("FAIL midrst_out sop=%b eop=%b fv=%b fp=%h pn=%0d required all 0", o_sop, o_eop, o_free_valid, o_free_ptr, o_port_num); end
    push(1, 8'd1, 8'h30);
    tick();
    tick();
    clear_logs();
    irst_n = 1'b1;
    #1;
    run(30);
    checks++;
    if (pops.size() == 0 || pops[0].a != 1)
      begin errors++; $display("FAIL midrst_first_port n=%0d mask=%0d required mask 1", pops.size(), pops.size() ? pops[0].a : 0); end
    checks++;
    if (frees.size() != 3 || frees[0].a != 8'h30 || frees[1].a != 8'h88 || frees[2].a != 8'h99)
      begin errors++; $display("FAIL midrst_frees n=%0d first=%h required 3 frees 30,88,99", frees.size(), frees.size() ? frees[0].a : 0); end
    foreach (frees[i]) begin
      checks++;
      if (frees[i].a == 8'h20) begin errors++; $display("FAIL midrst_abandoned_freed ptr=%h required never 20", frees[i].a); end
    end
  endtask

  task automatic test_random();
    int pushed, done, cur_port, cur_len, widx, model_last, exp_port, p;
    logic [7:0] cur_ptr, addr;
    logic [15:0] d;
    logic [2:0] exp_mask;
    bit active;
    reset_dut();
    rand_ready = 1'b1;
    pushed = 0; done = 0; model_last = 3; active = 1'b0;
    cur_port = 1; cur_len = 0; cur_ptr = 8'h00; widx = 0;
    for (int c = 0; c < 6000 && !(pushed == 40 && done == 40); c++) begin
      if (pushed < 40 && $urandom_range(0, 3) == 0) begin
        p = $urandom_range(1, 3);
        if (qsize(p) < 4) begin
          push(p, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
          pushed++;
        end
      end
      if (o_desc_pop != 3'b000) begin
        exp_port = rr_pick(i_desc_valid & i_port_ready, model_last);
        exp_mask = (exp_port == 0) ? 3'b000 : 3'(1 << (exp_port - 1));
        checks++;
        if (active || o_desc_pop !== exp_mask)
          begin errors++; $display("FAIL rand_pop cyc=%0d got=%b busy=%0d required=%b idle", cyc, o_desc_pop, active, exp_mask); end
        cur_port = o_desc_pop[0] ? 1 : (o_desc_pop[1] ? 2 : 3);
        d = qhead(cur_port);
        cur_len = int'(d[15:8]);
        cur_ptr = d[7:0];
        widx = 0;
        active = 1'b1;
      end
      if (o_ram_rd_en) begin
        checks++;
        if (!active || !i_port_ready[cur_port-1])
          begin errors++; $display("FAIL rand_rd_en cyc=%0d active=%0d ready=%b required active with ready", cyc, active, i_port_ready); end
      end
      if (o_data_valid) begin
        addr = 8'((int'(cur_ptr) + widx) % 256);
        checks++;
        if (!active || widx >= cur_len || o_data !== mem[addr] || o_sop !== (widx == 0) || o_eop !== (widx == cur_len - 1) || o_port_num !== 2'(cur_port))
          begin errors++; $display("FAIL rand_word cyc=%0d idx=%0d d=%h s=%b e=%b pn=%0d required %h/%0d/%0d/%0d of len %0d", cyc, widx, o_data, o_sop, o_eop, o_port_num, mem[addr], widx == 0, widx == cur_len - 1, cur_port, cur_len); end
        widx++;
      end
      if (o_free_valid) begin
        checks++;
        if (!active || o_free_ptr !== cur_ptr || widx != cur_len)
          begin errors++; $display("FAIL rand_free cyc=%0d ptr=%h words=%0d required %h/%0d", cyc, o_free_ptr, widx, cur_ptr, cur_len); end
        active = 1'b0;
        model_last = cur_port;
        done++;
      end
      tick();
    end
    checks++;
    if (pushed == 0 || done != pushed)
      begin errors++; $display("FAIL rand_completion freed=%0d required=%0d", done, pushed); end
    rand_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    irst_n = 1'b0;
    i_port_ready = 3'b111;
    i_desc_valid = 3'b000;
    i_desc_1 = '0; i_desc_2 = '0; i_desc_3 = '0;
    #2;
    test_reset();
    test_single();
    test_all_three();
    test_ready_drop();
    test_wrap();
    test_len0();
    test_reset_midpacket();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
